// File: rtl/comp_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : comp_div_pkg
// Brief    : Shared types, width helpers and output conversion for comp_div.
// Revision : 1.0 - initial release
// ============================================================================
package comp_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        DIV  = 2'd2,
        OUT  = 2'd3
    } state_t;

    function automatic int num_width(input int wi, input int wii);
        return wi + wii + 1;
    endfunction

    function automatic int den_width(input int wii);
        return 2 * wii;
    endfunction

    function automatic int quo_width(input int wi, input int wii, input int frac);
        return wi + wii + frac;
    endfunction

    // Saturate clamps to the signed ow-bit range; wrap passes the value
    // through so the caller keeps only the low ow bits.
    function automatic logic signed [63:0] fit_output(
        input logic signed [63:0] v,
        input int                 ow,
        input logic               sat
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        hi  = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (ow - 1));
        res = v;
        if (sat) begin
            if (v > hi) begin
                res = hi;
            end else if (v < lo) begin
                res = lo;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/divu_iter.sv
`default_nettype none
// ============================================================================
// Module   : divu_iter
// Brief    : Unsigned restoring divider, one quotient bit per enabled cycle.
// Revision : 1.0 - initial release
// ============================================================================
module divu_iter
    import comp_div_pkg::*;
#(
    parameter int DEN_W = 8,
    parameter int QUO_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [QUO_W-1:0] i_dividend,
    input  logic [DEN_W-1:0] i_divisor,
    output logic [QUO_W-1:0] o_quotient
);

    logic [DEN_W-1:0] r_rem;
    logic [QUO_W-1:0] r_quo;
    logic [DEN_W:0]   w_shift;
    logic             w_ge;
    logic [DEN_W-1:0] w_diff;

    // The dividend shifts out of the top of r_quo as quotient bits shift in.
    assign w_shift = {r_rem, r_quo[QUO_W-1]};
    assign w_ge    = (w_shift >= {1'b0, i_divisor});
    // A successful subtraction always leaves less than the divisor.
    assign w_diff  = w_shift[DEN_W-1:0] - i_divisor;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
        end else if (i_step) begin
            r_rem <= w_ge ? w_diff : w_shift[DEN_W-1:0];
            r_quo <= {r_quo[QUO_W-2:0], w_ge};
        end
    end

    assign o_quotient = r_quo;

endmodule
`default_nettype wire

// File: rtl/comp_div.sv
`default_nettype none
// ============================================================================
// Module   : comp_div
// Brief    : Sequential complex divider (a+jb)/(c+jd), fixed latency QW+2.
// Revision : 1.0 - initial release
// ============================================================================
module comp_div
    import comp_div_pkg::*;
#(
    parameter int INPUT_WIDTH_I  = 4,
    parameter int INPUT_WIDTH_II = 4,
    parameter int OUTPUT_WIDTH   = 4,
    parameter int FRAC_BITS      = 0,
    parameter int WRAP_SATURATE  = 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic signed [INPUT_WIDTH_I-1:0]  i_a,
    input  logic signed [INPUT_WIDTH_I-1:0]  i_b,
    input  logic signed [INPUT_WIDTH_II-1:0] i_c,
    input  logic signed [INPUT_WIDTH_II-1:0] i_d,
    input  logic                             i_valid_data,
    output logic                             o_ready,
    output logic signed [OUTPUT_WIDTH-1:0]   o_r,
    output logic signed [OUTPUT_WIDTH-1:0]   o_im,
    output logic                             o_valid_data,
    output logic                             o_div_by_zero
);

    localparam int c_num_w = num_width(INPUT_WIDTH_I, INPUT_WIDTH_II);
    localparam int c_mag_w = c_num_w - 1;
    localparam int c_den_w = den_width(INPUT_WIDTH_II);
    localparam int c_quo_w = quo_width(INPUT_WIDTH_I, INPUT_WIDTH_II, FRAC_BITS);
    localparam int c_cnt_w = ($clog2(c_quo_w) > 5) ? $clog2(c_quo_w) : 5;

    state_t r_state;
    state_t w_next;

    logic signed [INPUT_WIDTH_I-1:0]  r_a;
    logic signed [INPUT_WIDTH_I-1:0]  r_b;
    logic signed [INPUT_WIDTH_II-1:0] r_c;
    logic signed [INPUT_WIDTH_II-1:0] r_d;

    logic signed [c_num_w-1:0] w_a_x;
    logic signed [c_num_w-1:0] w_b_x;
    logic signed [c_num_w-1:0] w_c_x;
    logic signed [c_num_w-1:0] w_d_x;
    logic signed [c_num_w-1:0] w_num_re;
    logic signed [c_num_w-1:0] w_num_im;
    logic signed [c_den_w-1:0] w_c_y;
    logic signed [c_den_w-1:0] w_d_y;
    logic        [c_den_w-1:0] w_den;
    logic        [c_mag_w-1:0] w_mag_re;
    logic        [c_mag_w-1:0] w_mag_im;
    logic        [c_quo_w-1:0] w_dvd_re;
    logic        [c_quo_w-1:0] w_dvd_im;
    logic        [c_quo_w-1:0] w_quo_re;
    logic        [c_quo_w-1:0] w_quo_im;
    logic signed [c_quo_w:0]   w_sq_re;
    logic signed [c_quo_w:0]   w_sq_im;

    logic [c_den_w-1:0] r_den;
    logic               r_neg_re;
    logic               r_neg_im;
    logic               r_dbz;
    logic [c_cnt_w-1:0] r_cnt;

    logic w_accept;
    logic w_load;
    logic w_step;

    assign o_ready  = (r_state == IDLE);
    assign w_accept = i_valid_data && o_ready;
    assign w_load   = (r_state == PREP);
    assign w_step   = (r_state == DIV);

    // Products are formed at the full numerator width so no partial sum overflows.
    assign w_a_x = {{(c_num_w-INPUT_WIDTH_I){r_a[INPUT_WIDTH_I-1]}}, r_a};
    assign w_b_x = {{(c_num_w-INPUT_WIDTH_I){r_b[INPUT_WIDTH_I-1]}}, r_b};
    assign w_c_x = {{(c_num_w-INPUT_WIDTH_II){r_c[INPUT_WIDTH_II-1]}}, r_c};
    assign w_d_x = {{(c_num_w-INPUT_WIDTH_II){r_d[INPUT_WIDTH_II-1]}}, r_d};
    assign w_c_y = {{(c_den_w-INPUT_WIDTH_II){r_c[INPUT_WIDTH_II-1]}}, r_c};
    assign w_d_y = {{(c_den_w-INPUT_WIDTH_II){r_d[INPUT_WIDTH_II-1]}}, r_d};

    assign w_num_re = w_a_x * w_c_x + w_b_x * w_d_x;
    assign w_num_im = w_b_x * w_c_x - w_a_x * w_d_x;
    assign w_den    = w_c_y * w_c_y + w_d_y * w_d_y;

    // |num| never exceeds 2^(c_mag_w-1), so the sign bit can be dropped.
    assign w_mag_re = w_num_re[c_num_w-1] ? c_mag_w'(-w_num_re) : w_num_re[c_mag_w-1:0];
    assign w_mag_im = w_num_im[c_num_w-1] ? c_mag_w'(-w_num_im) : w_num_im[c_mag_w-1:0];
    assign w_dvd_re = c_quo_w'(w_mag_re) << FRAC_BITS;
    assign w_dvd_im = c_quo_w'(w_mag_im) << FRAC_BITS;

    divu_iter #(
        .DEN_W (c_den_w),
        .QUO_W (c_quo_w)
    ) u_div_re (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_dividend (w_dvd_re),
        .i_divisor  (r_den),
        .o_quotient (w_quo_re)
    );

    divu_iter #(
        .DEN_W (c_den_w),
        .QUO_W (c_quo_w)
    ) u_div_im (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_dividend (w_dvd_im),
        .i_divisor  (r_den),
        .o_quotient (w_quo_im)
    );

    assign w_sq_re = r_neg_re ? -$signed({1'b0, w_quo_re}) : $signed({1'b0, w_quo_re});
    assign w_sq_im = r_neg_im ? -$signed({1'b0, w_quo_im}) : $signed({1'b0, w_quo_im});

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_valid_data) w_next = PREP;
            PREP:    w_next = DIV;
            DIV:     if (r_cnt == '0) w_next = OUT;
            OUT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= '0;
            r_d           <= '0;
            r_den         <= '0;
            r_neg_re      <= 1'b0;
            r_neg_im      <= 1'b0;
            r_dbz         <= 1'b0;
            r_cnt         <= '0;
            o_r           <= '0;
            o_im          <= '0;
            o_valid_data  <= 1'b0;
            o_div_by_zero <= 1'b0;
        end else begin
            r_state      <= w_next;
            o_valid_data <= (r_state == OUT);
            if (w_accept) begin
                r_a <= i_a;
                r_b <= i_b;
                r_c <= i_c;
                r_d <= i_d;
            end
            if (r_state == PREP) begin
                r_den    <= w_den;
                r_neg_re <= w_num_re[c_num_w-1];
                r_neg_im <= w_num_im[c_num_w-1];
                r_dbz    <= (w_den == '0);
                r_cnt    <= c_cnt_w'(c_quo_w - 1);
            end else if ((r_state == DIV) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
            if (r_state == OUT) begin
                o_div_by_zero <= r_dbz;
                o_r  <= r_dbz ? '0 : OUTPUT_WIDTH'(fit_output(64'(w_sq_re), OUTPUT_WIDTH, WRAP_SATURATE != 0));
                o_im <= r_dbz ? '0 : OUTPUT_WIDTH'(fit_output(64'(w_sq_im), OUTPUT_WIDTH, WRAP_SATURATE != 0));
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_comp_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_comp_div
// Brief    : Directed self-checking bench for comp_div (saturate and wrap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_comp_div;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic valid = 1'b0;
    logic signed [3:0] a = '0;
    logic signed [3:0] b = '0;
    logic signed [3:0] c = '0;
    logic signed [3:0] d = '0;

    logic ready, vout, dbz;
    logic ready_w, vout_w, dbz_w;
    logic signed [3:0] r, im, r_w, im_w;

    int checks   = 0;
    int failures = 0;

    int q_r[$];
    int q_i[$];
    int q_z[$];

    always #5 clk = ~clk;

    comp_div #(
        .INPUT_WIDTH_I (4), .INPUT_WIDTH_II (4), .OUTPUT_WIDTH (4),
        .FRAC_BITS (0), .WRAP_SATURATE (1)
    ) u_sat (
        .i_clk (clk), .i_rst_n (rst_n),
        .i_a (a), .i_b (b), .i_c (c), .i_d (d),
        .i_valid_data (valid), .o_ready (ready),
        .o_r (r), .o_im (im),
        .o_valid_data (vout), .o_div_by_zero (dbz)
    );

    comp_div #(
        .INPUT_WIDTH_I (4), .INPUT_WIDTH_II (4), .OUTPUT_WIDTH (4),
        .FRAC_BITS (0), .WRAP_SATURATE (0)
    ) u_wrap (
        .i_clk (clk), .i_rst_n (rst_n),
        .i_a (a), .i_b (b), .i_c (c), .i_d (d),
        .i_valid_data (valid), .o_ready (ready_w),
        .o_r (r_w), .o_im (im_w),
        .o_valid_data (vout_w), .o_div_by_zero (dbz_w)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference quotient: truncate toward zero, clamp to 4-bit signed.
    function automatic int qmodel(input int num, input int den);
        int q;
        if (den == 0) return 0;
        q = num / den;
        if (q > 7)  q = 7;
        if (q < -8) q = -8;
        return q;
    endfunction

    task automatic do_div(input int ia, input int ib, input int ic, input int id,
                          input int er, input int ei, input int edz,
                          input int ewr, input int ewi, input string tag);
        int n;
        int busy;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_in"}, int'(ready), 1);
        a = 4'(ia); b = 4'(ib); c = 4'(ic); d = 4'(id);
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        n    = 0;
        busy = 0;
        while (!vout && n < 40) begin
            if (n >= 1 && ready) busy++;
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 10);
        check({tag, "_busy_ready"}, busy, 0);
        check({tag, "_r"}, int'(r), er);
        check({tag, "_im"}, int'(im), ei);
        check({tag, "_dbz"}, int'(dbz), edz);
        check({tag, "_wrap_valid"}, int'(vout_w), 1);
        check({tag, "_wrap_r"}, int'(r_w), ewr);
        check({tag, "_wrap_im"}, int'(im_w), ewi);
        check({tag, "_wrap_dbz"}, int'(dbz_w), edz);
        @(negedge clk);
        check({tag, "_pulse"}, int'(vout), 0);
        check({tag, "_ready_out"}, int'(ready), 1);
    endtask

    initial begin
        int ia, ib, ic, id, last, nstrobe, n;

        repeat (2) @(negedge clk);
        check("rst_ready", int'(ready), 1);
        check("rst_ready_w", int'(ready_w), 1);
        check("rst_r", int'(r), 0);
        check("rst_im", int'(im), 0);
        check("rst_valid", int'(vout), 0);
        check("rst_dbz", int'(dbz), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_div( 6,  0,  2,  0,   3, 0, 0,   3,  0, "real");
        do_div( 3,  4,  1,  2,   2, 0, 0,   2,  0, "trunc_pos");
        do_div(-3, -4,  1,  2,  -2, 0, 0,  -2,  0, "trunc_neg");
        do_div(-8,  0, -1,  0,   7, 0, 0,  -8,  0, "ovf_re");
        do_div(-8, -8,  0,  1,  -8, 7, 0,  -8, -8, "ovf_im");
        do_div( 7, -8, -3,  3,  -2, 0, 0,  -2,  0, "mixed");
        do_div( 7,  7,  1, -1,   0, 7, 0,   0,  7, "imag");
        do_div( 5, -3,  0,  0,   0, 0, 1,   0,  0, "dbz");
        do_div( 6,  0,  2,  0,   3, 0, 0,   3,  0, "dbz_clear");

        // Held valid with operands changing every cycle.
        last    = -1;
        nstrobe = 0;
        for (int cyc = 0; cyc < 46; cyc++) begin
            if (vout) begin
                nstrobe++;
                if (q_r.size() == 0) begin
                    check("hs_unexpected", 1, 0);
                end else begin
                    check("hs_r", int'(r), q_r.pop_front());
                    check("hs_im", int'(im), q_i.pop_front());
                    check("hs_dbz", int'(dbz), q_z.pop_front());
                end
                if (last >= 0) check("hs_spacing", cyc - last, 11);
                last = cyc;
            end
            ia = ((cyc * 5 + 3) % 16) - 8;
            ib = ((cyc * 3 + 7) % 16) - 8;
            ic = ((cyc * 7 + 1) % 16) - 8;
            id = ((cyc * 11 + 2) % 16) - 8;
            a = 4'(ia); b = 4'(ib); c = 4'(ic); d = 4'(id);
            valid = (cyc < 33);
            if (valid && ready) begin
                q_r.push_back(qmodel(ia * ic + ib * id, ic * ic + id * id));
                q_i.push_back(qmodel(ib * ic - ia * id, ic * ic + id * id));
                q_z.push_back((ic == 0 && id == 0) ? 1 : 0);
            end
            @(negedge clk);
        end
        valid = 1'b0;
        check("hs_count", nstrobe, 3);

        // Abort mid-division: leave a non-zero result first.
        do_div(6, 0, 2, 0, 3, 0, 0, 3, 0, "pre_abort");
        a = 4'sd3; b = 4'sd4; c = 4'sd1; d = 4'sd2;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ready", int'(ready), 1);
        check("abort_r", int'(r), 0);
        check("abort_r_w", int'(r_w), 0);
        check("abort_im", int'(im), 0);
        check("abort_valid", int'(vout), 0);
        check("abort_dbz", int'(dbz), 0);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (vout) n++;
        end
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (vout) n++;
        end
        check("abort_no_strobe", n, 0);
        do_div(3, 4, 1, 2, 2, 0, 0, 2, 0, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
